// File: rtl/write_gen.sv
// Write-side stimulus generator for the async FIFO write port (wclk domain).
// Produces a parity-filtered sequence and pushes it under wfull back-pressure.
module write_gen #(
  parameter int unsigned     DW   = 16,
  parameter int unsigned     CW   = 16,
  parameter int unsigned     STEP = 1,
  parameter logic [DW-1:0]   SEED = '0,
  parameter logic [DW-1:0]   POLY = 16'hB400
) (
  input  logic          wclk,
  input  logic          wrst_n,
  input  logic          start,
  input  logic          stop,
  input  logic [1:0]    mode,
  input  logic [1:0]    par_sel,
  input  logic [CW-1:0] burst_len,
  input  logic          wfull,
  output logic          winc,
  output logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] wr_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_GEN, ST_WRITE, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] seq;
  logic [DW-1:0] cand;
  logic          accept;
  logic [1:0]    mode_r;
  logic [1:0]    par_r;
  logic [CW-1:0] blen_r;
  logic [DW-1:0] seed_load;

  function automatic logic [DW-1:0] next_val(input logic [DW-1:0] s, input logic [1:0] m);
    logic [DW-1:0] r;
    case (m)
      2'd0:    r = s + {{(DW-1){1'b0}}, 1'b1};
      2'd1:    r = s + DW'(STEP);
      2'd2:    r = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
      default: r = s - {{(DW-1){1'b0}}, 1'b1};
    endcase
    return r;
  endfunction

  function automatic logic parity_ok(input logic [DW-1:0] v, input logic [1:0] ps);
    logic r;
    case (ps)
      2'd1:    r = ^v;
      2'd2:    r = ~^v;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // An all-zero LFSR state never leaves zero, so a zero seed is replaced by 1.
  assign seed_load = (mode == 2'd2 && SEED == '0) ? {{(DW-1){1'b0}}, 1'b1} : SEED;
  assign cand      = next_val(seq, mode_r);
  assign accept    = parity_ok(cand, par_r);
  assign busy      = (state_q == ST_GEN) || (state_q == ST_WRITE);
  assign done      = (state_q == ST_DONE);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    winc    = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (start) state_d = ST_GEN;
        ST_GEN:           if (accept) state_d = ST_WRITE;
        ST_WRITE: begin
          if (!wfull) begin
            winc = 1'b1;
            if (blen_r != '0 && (wr_count + 1'b1) == blen_r) state_d = ST_DONE;
            else                                              state_d = ST_GEN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      seq      <= '0;
      wdata    <= '0;
      wr_count <= '0;
      mode_r   <= '0;
      par_r    <= '0;
      blen_r   <= '0;
    end else if (!stop) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mode_r   <= mode;
            par_r    <= par_sel;
            blen_r   <= burst_len;
            seq      <= seed_load;
            wr_count <= '0;
          end
        end
        ST_GEN: begin
          seq <= cand;
          if (accept) wdata <= cand;
        end
        ST_WRITE: if (winc) wr_count <= wr_count + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_write_gen.sv
// Directed bench for write_gen: two instances (SEED 0 and SEED 1) share all inputs.
module tb_write_gen;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic        start, stop, wfull;
  logic [1:0]  mode, par_sel;
  logic [15:0] burst_len;

  logic        winc0, busy0, done0;
  logic [15:0] wdata0, wr_count0;
  logic        winc1, busy1, done1;
  logic [15:0] wdata1, wr_count1;

  int vectors = 0;
  int miscompares = 0;

  write_gen #(.DW(16), .CW(16), .STEP(1), .SEED(16'd0), .POLY(16'hB400)) u_dut0 (
    .wclk(wclk), .wrst_n(wrst_n), .start(start), .stop(stop), .mode(mode),
    .par_sel(par_sel), .burst_len(burst_len), .wfull(wfull), .winc(winc0),
    .wdata(wdata0), .busy(busy0), .done(done0), .wr_count(wr_count0)
  );

  write_gen #(.DW(16), .CW(16), .STEP(1), .SEED(16'd1), .POLY(16'hB400)) u_dut1 (
    .wclk(wclk), .wrst_n(wrst_n), .start(start), .stop(stop), .mode(mode),
    .par_sel(par_sel), .burst_len(burst_len), .wfull(wfull), .winc(winc1),
    .wdata(wdata1), .busy(busy1), .done(done1), .wr_count(wr_count1)
  );

  always #5 wclk = ~wclk;

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic restart();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic go(input logic [1:0] m, input logic [1:0] p, input logic [15:0] bl);
    mode = m; par_sel = p; burst_len = bl;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits (bounded) for a write request, checks its data, then checks the pulse ends.
  task automatic expect_write(input string tag, input logic [15:0] exp0,
                              input bit use1, input logic [15:0] exp1);
    int n = 0;
    while (winc0 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_winc"}, winc0, 1);
    chk({tag, "_wdata"}, wdata0, exp0);
    if (use1) begin
      chk({tag, "_winc1"}, winc1, 1);
      chk({tag, "_wdata1"}, wdata1, exp1);
    end
    tick();
    chk({tag, "_pulse_end"}, winc0, 0);
  endtask

  initial begin
    wrst_n = 1'b0; start = 1'b0; stop = 1'b0; wfull = 1'b0;
    mode = 2'd0; par_sel = 2'd1; burst_len = 16'd4;
    #12;
    chk("rst_winc", winc0, 0);
    chk("rst_wdata", wdata0, 0);
    chk("rst_count", wr_count0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    wrst_n = 1'b1;
    tick();

    // Odd-parity filter on +1 sequence: 1, 2, 4, 7
    go(2'd0, 2'd1, 16'd4);
    chk("t1_busy", busy0, 1);
    expect_write("t1_w0", 16'h0001, 0, 0);
    expect_write("t1_w1", 16'h0002, 0, 0);
    expect_write("t1_w2", 16'h0004, 0, 0);
    expect_write("t1_w3", 16'h0007, 0, 0);
    chk("t1_done", done0, 1);
    chk("t1_busy_end", busy0, 0);
    chk("t1_count", wr_count0, 4);
    chk("t1_wdata_hold", wdata0, 16'h0007);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_done_nowinc", winc0, 0);
    end

    // Back-pressure: wfull held during the first WRITE
    restart();
    go(2'd0, 2'd0, 16'd3);
    wfull = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_full_winc", winc0, 0);
      chk("t2_full_wdata", wdata0, 16'h0001);
      chk("t2_full_count", wr_count0, 0);
      tick();
    end
    wfull = 1'b0;
    #1;
    expect_write("t2_w0", 16'h0001, 0, 0);
    expect_write("t2_w1", 16'h0002, 0, 0);
    expect_write("t2_w2", 16'h0003, 0, 0);
    chk("t2_done", done0, 1);
    chk("t2_count", wr_count0, 3);

    // Decrement wrap: SEED 0 -> FFFF, FFFE, FFFD; SEED 1 -> 0, FFFF, FFFE
    restart();
    go(2'd3, 2'd0, 16'd3);
    expect_write("t3_w0", 16'hFFFF, 1, 16'h0000);
    expect_write("t3_w1", 16'hFFFE, 1, 16'hFFFF);
    expect_write("t3_w2", 16'hFFFD, 1, 16'hFFFE);
    chk("t3_done1", done1, 1);

    // LFSR with zero seed forced to 1
    restart();
    go(2'd2, 2'd0, 16'd2);
    expect_write("t4_w0", 16'hB400, 0, 0);
    expect_write("t4_w1", 16'h5A00, 0, 0);
    chk("t4_done", done0, 1);

    // Continuous run aborted by stop on a WRITE cycle
    restart();
    go(2'd0, 2'd0, 16'd0);
    expect_write("t5_w0", 16'h0001, 0, 0);
    expect_write("t5_w1", 16'h0002, 0, 0);
    tick();
    chk("t5_pre_winc", winc0, 1);
    stop = 1'b1;
    #1;
    chk("t5_stop_winc", winc0, 0);
    tick();
    stop = 1'b0;
    #1;
    chk("t5_busy", busy0, 0);
    chk("t5_done", done0, 0);
    chk("t5_count", wr_count0, 2);
    chk("t5_wdata", wdata0, 16'h0003);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    #1;
    chk("t5_stop_wins", busy0, 0);

    // Asynchronous reset mid-WRITE
    go(2'd0, 2'd0, 16'd0);
    expect_write("t6_w0", 16'h0001, 0, 0);
    tick();
    chk("t6_pre_winc", winc0, 1);
    wrst_n = 1'b0;
    #1;
    chk("t6_winc", winc0, 0);
    chk("t6_wdata", wdata0, 0);
    chk("t6_count", wr_count0, 0);
    chk("t6_busy", busy0, 0);
    chk("t6_done", done0, 0);
    #3;
    wrst_n = 1'b1;
    tick();
    tick();
    chk("t6_idle_busy", busy0, 0);
    chk("t6_idle_winc", winc0, 0);
    chk("t6_idle_count", wr_count0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
